// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-organised data memory.
// Handles sub-word loads by extension and sub-word stores by read-modify-write.
module load_store_unit #(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state, state_next;
  logic [1:0]  lane_q;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;
  logic        accept;
  logic        req_err;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_W) req_err = 1'b1;
    if (req_we) begin
      case (req_funct3)
        3'b000:  ;
        3'b001:  if (req_addr[0]) req_err = 1'b1;
        3'b010:  if (req_addr[1:0] != 2'b00) req_err = 1'b1;
        default: req_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b100: ;
        3'b001, 3'b101: if (req_addr[0]) req_err = 1'b1;
        3'b010:         if (req_addr[1:0] != 2'b00) req_err = 1'b1;
        default:        req_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (req_err)                  state_next = RESP;
          else if (!req_we)             state_next = LOAD;
          else if (req_funct3 == 3'b010) state_next = WRITE;
          else                          state_next = MERGE;
        end
      end
      LOAD:  state_next = RESP;
      MERGE: state_next = WRITE;
      WRITE: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // funct3[0] distinguishes sh from sb on the read-modify-write path.
  always_comb begin
    merged = mem_rdata;
    if (funct3_q[0]) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  // Response registers change only on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= 2'b00;
      funct3_q  <= 3'b000;
      wdata_q   <= 16'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      if (accept) begin
        lane_q   <= req_addr[1:0];
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata[15:0];
        mem_addr <= {req_addr[31:2], 2'b00};
        if (req_we) mem_wdata <= req_wdata;
        if (req_err) begin
          rsp_rdata <= 32'h0;
          rsp_error <= 1'b1;
        end
      end
      if (state == LOAD) begin
        rsp_rdata <= load_data;
        rsp_error <= 1'b0;
      end
      if (state == MERGE) mem_wdata <= merged;
      if (state == WRITE) begin
        rsp_rdata <= 32'h0;
        rsp_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests compared against a word-array reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];

  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;
  logic [31:0] we_addr, we_data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // Data memory: asynchronous read, synchronous full-word write.
  always_comb mem_rdata = (mem_addr[31:2] < 30'd512) ? mem[mem_addr[10:2]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_addr[31:2] < 30'd512) mem[mem_addr[10:2]] <= mem_wdata;

  always @(negedge clk) begin
    if (mem_we) begin
      we_count = we_count + 1;
      we_addr  = mem_addr;
      we_data  = mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request from a negedge and returns at the negedge of its response cycle.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic hold);
    logic        exp_err;
    logic [31:0] exp_rdata, old, newword, mask;
    int          exp_lat, lat, wc0, sh, v;
    bit          ok;

    sh = int'(addr % 4) * 8;
    exp_err = (addr / 4) >= 512;
    if (we) begin
      case (f3)
        3'd0: ;
        3'd1: if (addr % 2 != 0) exp_err = 1'b1;
        3'd2: if (addr % 4 != 0) exp_err = 1'b1;
        default: exp_err = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: ;
        3'd1, 3'd5: if (addr % 2 != 0) exp_err = 1'b1;
        3'd2: if (addr % 4 != 0) exp_err = 1'b1;
        default: exp_err = 1'b1;
      endcase
    end
    old = exp_err ? 32'h0 : ref_mem[addr[10:2]];
    exp_rdata = 32'h0;
    newword = old;
    if (!exp_err && !we) begin
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = int'((old >> sh) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        v = int'((old >> sh) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end else begin
        v = int'(old);
      end
      exp_rdata = 32'(v);
    end
    if (!exp_err && we) begin
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
      newword = (old & ~(mask << sh)) | ((wdata & mask) << sh);
    end
    exp_lat = exp_err ? 1 : (we ? ((f3 == 3'd2) ? 2 : 3) : 2);

    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wc0 = we_count;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(posedge clk); @(negedge clk);
      checkOutput("rsp_pulse_len", 32'(rsp_valid), 32'd0);
    end
    if (!ok) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); @(negedge clk);
    if (!hold) req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      checkOutput("ready_busy", 32'(req_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("ready_in_resp", 32'(req_ready), 32'd0);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_error", 32'(rsp_error), 32'(exp_err));
    checkOutput("mem_addr_hold", mem_addr, {addr[31:2], 2'b00});
    checkOutput("we_pulses", 32'(we_count - wc0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      checkOutput("we_addr", we_addr, {addr[31:2], 2'b00});
      checkOutput("we_data", we_data, newword);
      ref_mem[addr[10:2]] = newword;
    end
  endtask

  initial begin
    int wc0;
    logic [31:0] a;
    for (int i = 0; i < 512; i++) begin
      mem[i] = (i * 32'h01010101) ^ 32'hA5C3_0F96;
      ref_mem[i] = mem[i];
    end
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_error", 32'(rsp_error), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort an sb while it is in MERGE.
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h22; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    wc0 = we_count;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_write", 32'(we_count - wc0), 32'd0);
    checkOutput("abort_ready_after", 32'(req_ready), 32'd1);
    checkOutput("abort_mem_intact", mem[8], ref_mem[8]);

    applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    checkOutput("tv_lw", rsp_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'd0, 32'h12, 32'h55, 1'b0);
    checkOutput("tv_sb_word", mem[4], 32'hDE55BEEF);
    applyStimulus(1'b0, 3'd0, 32'h12, 32'h0, 1'b0);
    checkOutput("tv_lb12", rsp_rdata, 32'h00000055);
    applyStimulus(1'b0, 3'd0, 32'h13, 32'h0, 1'b0);
    checkOutput("tv_lb13", rsp_rdata, 32'hFFFFFFDE);
    applyStimulus(1'b0, 3'd4, 32'h13, 32'h0, 1'b0);
    checkOutput("tv_lbu13", rsp_rdata, 32'h000000DE);
    applyStimulus(1'b1, 3'd2, 32'h14, 32'h11223344, 1'b0);
    applyStimulus(1'b1, 3'd1, 32'h16, 32'h8001, 1'b0);
    checkOutput("tv_sh_word", mem[5], 32'h80013344);
    applyStimulus(1'b0, 3'd1, 32'h16, 32'h0, 1'b0);
    checkOutput("tv_lh", rsp_rdata, 32'hFFFF8001);
    applyStimulus(1'b0, 3'd5, 32'h16, 32'h0, 1'b0);
    checkOutput("tv_lhu", rsp_rdata, 32'h00008001);

    applyStimulus(1'b0, 3'd2, 32'h11, 32'h0, 1'b0);
    checkOutput("tv_err_lw", 32'(rsp_error), 32'd1);
    applyStimulus(1'b1, 3'd1, 32'h13, 32'h1234, 1'b0);
    checkOutput("tv_err_sh", 32'(rsp_error), 32'd1);
    applyStimulus(1'b0, 3'd3, 32'h10, 32'h0, 1'b0);
    checkOutput("tv_err_f3", 32'(rsp_error), 32'd1);
    applyStimulus(1'b1, 3'd2, 32'h800, 32'hCAFEF00D, 1'b0);
    checkOutput("tv_err_range", 32'(rsp_error), 32'd1);

    // Back-to-back with req_valid held high.
    applyStimulus(1'b1, 3'd2, 32'h20, 32'h01234567, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    applyStimulus(1'b1, 3'd0, 32'h21, 32'hAB, 1'b1);
    applyStimulus(1'b0, 3'd4, 32'h21, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'd6, 32'h20, 32'h0, 1'b1);
    applyStimulus(1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    req_valid = 1'b0;

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = (32'd512 + $urandom_range(0, 1000)) * 4;
      else                           a = $urandom_range(0, 15) * 4;
      a = a + $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                    1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
